// File: rtl/pipe_int_ctrl.sv
// Pipeline hazard / flush controller with precise external-interrupt entry and eret return.
// Drives PC and IF/ID, ID/EX, EX/MEM register controls; holds EPC and the interrupt-enable bit.
module pipe_int_ctrl #(
  parameter logic [31:0] VECTOR      = 32'h0000_4180,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          IE_RESET    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_in,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_eret,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wa,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_clear,
  output logic        idex_clear,
  output logic        exmem_clear,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc_out,
  output logic        ie_out,
  output logic        int_ack
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ENTER = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PC_DP  = 2'b00,
    PC_VEC = 2'b01,
    PC_EPC = 2'b10
  } pc_sel_e;

  // The handler address is consumed by the datapath mux; here it only has to be word aligned.
  if (VECTOR[1:0] != 2'b00) begin : g_bad_vector
    $error("pipe_int_ctrl: VECTOR must be word aligned");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pipe_int_ctrl: SYNC_STAGES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [31:0]            epc_q, epc_d;
  logic                   ie_q, ie_d;
  logic                   irq_p;
  logic                   lu;
  logic                   irq_ok;
  pc_sel_e                sel;

  assign irq_p = sync_q[SYNC_STAGES-1];

  assign lu = ex_mem_read && (ex_wa != 5'd0) &&
              ((id_uses_rs && (ex_wa == id_rs)) || (id_uses_rt && (ex_wa == id_rt)));

  // ENTER and HOLD mask interrupts; HOLD guarantees one instruction at EPC retires first.
  assign irq_ok = (state_q == RUN) && irq_p && ie_q && ex_valid && !lu;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      sync_q  <= '0;
      epc_q   <= 32'h0;
      ie_q    <= IE_RESET;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
      epc_q   <= epc_d;
      ie_q    <= ie_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_clear  = 1'b0;
    idex_clear  = 1'b0;
    exmem_clear = 1'b0;
    sel         = PC_DP;
    state_d     = RUN;
    epc_d       = epc_q;
    ie_d        = ie_q;

    if (!rst) begin
      if (branch_taken) begin
        // Flush wins over everything, including a stall, so IF/ID is never both held and cleared.
        ifid_clear = 1'b1;
        idex_clear = 1'b1;
      end else if (id_eret) begin
        sel        = PC_EPC;
        ifid_clear = 1'b1;
        ie_d       = 1'b1;
        state_d    = HOLD;
      end else if (irq_ok) begin
        epc_d       = ex_pc;
        ie_d        = 1'b0;
        exmem_clear = 1'b1;
        idex_clear  = 1'b1;
        ifid_clear  = 1'b1;
        sel         = PC_VEC;
        state_d     = ENTER;
      end else if (lu) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_clear = 1'b1;
      end
    end
  end

  assign pc_sel  = sel;
  assign int_ack = (state_q == ENTER);
  assign epc_out = epc_q;
  assign ie_out  = ie_q;

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Directed bench for pipe_int_ctrl: expected control/EPC/IE words are queued as each
// step is driven and popped for comparison at the following falling edge.
module tb_pipe_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_in;
  logic [4:0]  id_rs, id_rt, ex_wa;
  logic        id_uses_rs, id_uses_rt, id_eret;
  logic        ex_mem_read, ex_valid, branch_taken;
  logic [31:0] ex_pc;
  logic        pc_write, ifid_write, ifid_clear, idex_clear, exmem_clear;
  logic [1:0]  pc_sel;
  logic [31:0] epc_out;
  logic        ie_out, int_ack;

  typedef struct {
    string       tag;
    logic [40:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] D, STALL, FLUSH, ACC, ENT, ERET;

  pipe_int_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_eret      (id_eret),
    .ex_mem_read  (ex_mem_read),
    .ex_wa        (ex_wa),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_clear   (ifid_clear),
    .idex_clear   (idex_clear),
    .exmem_clear  (exmem_clear),
    .pc_sel       (pc_sel),
    .epc_out      (epc_out),
    .ie_out       (ie_out),
    .int_ack      (int_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cv(input logic pcw, input logic ifw, input logic ifc,
                                    input logic idc, input logic emc,
                                    input logic [1:0] sel, input logic ack);
    return {pcw, ifw, ifc, idc, emc, sel, ack};
  endfunction

  // Queue the expectation, compare at the falling edge, then move to #1 after the next rise.
  task automatic chk(input string tag, input logic [7:0] c, input logic [31:0] e, input logic ie);
    exp_t        x;
    logic [40:0] got;
    x.tag = tag;
    x.v   = {c, e, ie};
    sb.push_back(x);
    @(negedge clk);
    got = {pc_write, ifid_write, ifid_clear, idex_clear, exmem_clear, pc_sel, int_ack,
           epc_out, ie_out};
    x = sb.pop_front();
    n_vec++;
    assert (got === x.v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", x.tag, got, x.v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rs   = 1'b0;
    id_uses_rt   = 1'b0;
    id_eret      = 1'b0;
    ex_mem_read  = 1'b0;
    ex_wa        = 5'd0;
    ex_valid     = 1'b1;
    branch_taken = 1'b0;
  endtask

  initial begin
    D     = cv(1, 1, 0, 0, 0, 2'b00, 0);
    STALL = cv(0, 0, 0, 1, 0, 2'b00, 0);
    FLUSH = cv(1, 1, 1, 1, 0, 2'b00, 0);
    ACC   = cv(1, 1, 1, 1, 1, 2'b01, 0);
    ENT   = cv(1, 1, 0, 0, 0, 2'b00, 1);
    ERET  = cv(1, 1, 1, 0, 0, 2'b10, 0);

    rst    = 1'b1;
    irq_in = 1'b0;
    ex_pc  = 32'h0;
    idle();
    chk("reset", D, 32'h0, 1'b1);

    rst = 1'b0;
    chk("idle", D, 32'h0, 1'b1);

    ex_mem_read = 1'b1; ex_wa = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    chk("lu_rs", STALL, 32'h0, 1'b1);
    ex_wa = 5'd0; id_rs = 5'd0;
    chk("lu_r0", D, 32'h0, 1'b1);
    ex_wa = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_uses_rs = 1'b0;
    chk("lu_rt", STALL, 32'h0, 1'b1);
    id_uses_rt = 1'b0;
    chk("rt_unused", D, 32'h0, 1'b1);
    id_uses_rt = 1'b1; id_eret = 1'b1; branch_taken = 1'b1;
    chk("br_prio", FLUSH, 32'h0, 1'b1);
    idle();
    chk("post_br", D, 32'h0, 1'b1);

    irq_in = 1'b1; ex_pc = 32'h0000_3010;
    chk("irq_sync0", D, 32'h0, 1'b1);
    chk("irq_sync1", D, 32'h0, 1'b1);
    chk("irq_accept", ACC, 32'h0, 1'b1);
    ex_pc = 32'h0000_3014;
    chk("enter", ENT, 32'h0000_3010, 1'b0);
    chk("ie_masked", D, 32'h0000_3010, 1'b0);
    id_eret = 1'b1;
    chk("eret", ERET, 32'h0000_3010, 1'b0);
    id_eret = 1'b0; ex_pc = 32'h0000_3020;
    chk("hold_mask", D, 32'h0000_3010, 1'b1);
    chk("reaccept", ACC, 32'h0000_3010, 1'b1);

    chk_now("enter_pre_rst", int_ack, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_in_enter", D, 32'h0, 1'b1);

    rst = 1'b0; ex_valid = 1'b0;
    chk("post_rst0", D, 32'h0, 1'b1);
    chk("post_rst1", D, 32'h0, 1'b1);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_wa = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ex_pc = 32'h0000_5000;
    chk("defer_lu", STALL, 32'h0, 1'b1);
    idle(); branch_taken = 1'b1;
    chk("defer_br", FLUSH, 32'h0, 1'b1);
    branch_taken = 1'b0; ex_valid = 1'b0;
    chk("defer_nv0", D, 32'h0, 1'b1);
    chk("defer_nv1", D, 32'h0, 1'b1);
    ex_valid = 1'b1; ex_pc = 32'h0000_5004;
    chk("late_accept", ACC, 32'h0, 1'b1);
    irq_in = 1'b0;
    chk("late_enter", ENT, 32'h0000_5004, 1'b0);
    chk("final", D, 32'h0000_5004, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
